wooden_man_game_ctrl: RTL



---
 rtl/wooden_man_game_ctrl.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/wooden_man_game_ctrl.sv
// Game-state producer for the two-player "1-2-3 wooden man" screen.
// Owns the match clock, the doll phase clock, player positions, sprites and
// survive/die conditions. Every output comes straight from a register.
module wooden_man_game_ctrl #(
  parameter int TICK_DIV  = 100000000,
  parameter int GAME_SEC  = 90,
  parameter int GO_SEC    = 5,
  parameter int WATCH_SEC = 3,
  parameter int GOAL      = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       p1_step,
  input  logic       p2_step,
  output logic       black,
  output logic       minute,
  output logic [3:0] sec1,
  output logic [3:0] sec0,
  output logic [3:0] remain1,
  output logic [3:0] remain0,
  output logic       doll_watch,
  output logic [4:0] p1_pos,
  output logic [2:0] p1_pic,
  output logic [1:0] p1_cond,
  output logic [4:0] p2_pos,
  output logic [2:0] p2_pic,
  output logic [1:0] p2_cond
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} state_t;

  localparam logic [1:0] COND_PLAY    = 2'd0;
  localparam logic [1:0] COND_SURVIVE = 2'd1;
  localparam logic [1:0] COND_DIE     = 2'd2;

  localparam logic [2:0] PIC_DIE  = 3'd0;
  localparam logic [2:0] PIC_LEFT = 3'd1;
  localparam logic [2:0] PIC_MID  = 3'd2;
  localparam logic [2:0] PIC_MID2 = 3'd4;

  typedef struct packed {
    logic [4:0] pos;
    logic [2:0] pic;
    logic [1:0] cond;
  } player_t;

  localparam player_t PLAYER_INIT = '{pos: 5'd0, pic: PIC_MID, cond: COND_PLAY};

  // Match length and phase lengths pre-split into BCD digits.
  localparam int         GAME_MIN = (GAME_SEC >= 60) ? 1 : 0;
  localparam int         GAME_REM = GAME_SEC - 60 * GAME_MIN;
  localparam logic       GAME_M   = 1'(GAME_MIN);
  localparam logic [3:0] GAME_S1  = 4'(GAME_REM / 10);
  localparam logic [3:0] GAME_S0  = 4'(GAME_REM % 10);
  localparam logic [3:0] GO_R1    = 4'(GO_SEC / 10);
  localparam logic [3:0] GO_R0    = 4'(GO_SEC % 10);
  localparam logic [3:0] WATCH_R1 = 4'(WATCH_SEC / 10);
  localparam logic [3:0] WATCH_R0 = 4'(WATCH_SEC % 10);

  localparam logic [26:0] TICK_LAST = 27'(TICK_DIV - 1);
  localparam logic [4:0]  GOAL_POS  = 5'(GOAL);

  state_t      state_q, state_d;
  logic        black_q, black_d;
  logic        minute_q, minute_d;
  logic [3:0]  sec1_q, sec1_d;
  logic [3:0]  sec0_q, sec0_d;
  logic [3:0]  rem1_q, rem1_d;
  logic [3:0]  rem0_q, rem0_d;
  logic        watch_q, watch_d;
  logic [26:0] cnt_q, cnt_d;
  player_t     p1_q, p1_d;
  player_t     p2_q, p2_d;

  logic time_zero;
  logic time_one;
  logic tick;

  // Update one player for this cycle. Steps are judged against the doll
  // direction held before any tick of the same cycle; a step that reaches the
  // goal on the timeout cycle still survives because timeout is applied last.
  function automatic player_t player_next(input player_t cur, input logic step,
                                          input logic watch, input logic timeout);
    player_t nxt;
    nxt = cur;
    if (cur.cond == COND_PLAY && step) begin
      if (watch) begin
        nxt.cond = COND_DIE;
        nxt.pic  = PIC_DIE;
      end else begin
        nxt.pos = cur.pos + 5'd1;
        nxt.pic = (cur.pic == PIC_MID2) ? PIC_LEFT : cur.pic + 3'd1;
        if (nxt.pos == GOAL_POS) nxt.cond = COND_SURVIVE;
      end
    end
    if (timeout && nxt.cond == COND_PLAY) begin
      nxt.cond = COND_DIE;
      nxt.pic  = PIC_DIE;
    end
    return nxt;
  endfunction

  assign time_zero = (minute_q == 1'b0) && (sec1_q == 4'd0) && (sec0_q == 4'd0);
  assign time_one  = (minute_q == 1'b0) && (sec1_q == 4'd0) && (sec0_q == 4'd1);
  assign tick      = (state_q == S_PLAY) && !time_zero && (cnt_q == TICK_LAST);

  // Next-state and datapath: match start, second tick, clock digits, players.
  always_comb begin
    // NOTE: every _d gets a hold default first so no path leaves a latch.
    state_d  = state_q;
    black_d  = black_q;
    minute_d = minute_q;
    sec1_d   = sec1_q;
    sec0_d   = sec0_q;
    rem1_d   = rem1_q;
    rem0_d   = rem0_q;
    watch_d  = watch_q;
    cnt_d    = cnt_q;
    p1_d     = p1_q;
    p2_d     = p2_q;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d  = S_PLAY;
          black_d  = 1'b0;
          minute_d = GAME_M;
          sec1_d   = GAME_S1;
          sec0_d   = GAME_S0;
          rem1_d   = GO_R1;
          rem0_d   = GO_R0;
          watch_d  = 1'b0;
          cnt_d    = '0;
          p1_d     = PLAYER_INIT;
          p2_d     = PLAYER_INIT;
        end
      end

      S_PLAY: begin
        if (p1_q.cond != COND_PLAY && p2_q.cond != COND_PLAY) state_d = S_OVER;

        // The second counter freezes once the match clock has run out.
        if (!time_zero) cnt_d = tick ? '0 : cnt_q + 27'd1;

        if (tick) begin
          if (sec0_q != 4'd0) begin
            sec0_d = sec0_q - 4'd1;
          end else begin
            sec0_d = 4'd9;
            if (sec1_q != 4'd0) begin
              sec1_d = sec1_q - 4'd1;
            end else begin
              sec1_d   = 4'd5;
              minute_d = 1'b0;
            end
          end

          if (rem1_q == 4'd0 && rem0_q == 4'd1) begin
            watch_d = !watch_q;
            if (!watch_q) begin
              rem1_d = WATCH_R1;
              rem0_d = WATCH_R0;
            end else begin
              rem1_d = GO_R1;
              rem0_d = GO_R0;
            end
          end else if (rem0_q != 4'd0) begin
            rem0_d = rem0_q - 4'd1;
          end else begin
            rem0_d = 4'd9;
            rem1_d = rem1_q - 4'd1;
          end
        end

        p1_d = player_next(p1_q, p1_step, watch_q, tick && time_one);
        p2_d = player_next(p2_q, p2_step, watch_q, tick && time_one);
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset to the blanked idle screen.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q  <= S_IDLE;
      black_q  <= 1'b1;
      minute_q <= GAME_M;
      sec1_q   <= GAME_S1;
      sec0_q   <= GAME_S0;
      rem1_q   <= GO_R1;
      rem0_q   <= GO_R0;
      watch_q  <= 1'b0;
      cnt_q    <= '0;
      p1_q     <= PLAYER_INIT;
      p2_q     <= PLAYER_INIT;
    end else begin
      state_q  <= state_d;
      black_q  <= black_d;
      minute_q <= minute_d;
      sec1_q   <= sec1_d;
      sec0_q   <= sec0_d;
      rem1_q   <= rem1_d;
      rem0_q   <= rem0_d;
      watch_q  <= watch_d;
      cnt_q    <= cnt_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
    end
  end

  assign black      = black_q;
  assign minute     = minute_q;
  assign sec1       = sec1_q;
  assign sec0       = sec0_q;
  assign remain1    = rem1_q;
  assign remain0    = rem0_q;
  assign doll_watch = watch_q;
  assign p1_pos     = p1_q.pos;
  assign p1_pic     = p1_q.pic;
  assign p1_cond    = p1_q.cond;
  assign p2_pos     = p2_q.pos;
  assign p2_pic     = p2_q.pic;
  assign p2_cond    = p2_q.cond;

endmodule
